// File: rtl/spi_mcp4822_dac_if.sv
// Sample-in / SPI-out bundle for the MCP4822 DAC writer.
// master = DAC SPI writer, slave = the sample source and the DAC pins it drives.
interface spi_mcp4822_dac_if;
  logic [11:0] data_in;
  logic        dv_in;
  logic        mosi;
  logic        sck;
  logic        cs;
  logic        ldac;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (
    input  data_in, dv_in,
    output mosi, sck, cs, ldac, busy, done, ovf
  );

  modport slave (
    output data_in, dv_in,
    input  mosi, sck, cs, ldac, busy, done, ovf
  );
endinterface

// File: rtl/spi_mcp4822_dac.sv
// MCP4822 SPI writer: one 16-bit frame plus LDAC strobe per dv_in rising edge,
// with a one-deep pending buffer for samples arriving mid-frame.
module spi_mcp4822_dac #(
  parameter int unsigned CLK_DIV      = 100,
  parameter bit          CHANNEL      = 1'b0,
  parameter bit          GAIN_1X      = 1'b1,
  parameter int unsigned CS_HIGH_CNTS = 10,
  parameter int unsigned LDAC_CNTS    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mcp4822_dac_if.master bus
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned BIT_W   = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_CS_HOLD = 2'd2;
  localparam logic [1:0] ST_LDAC    = 2'd3;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_HALF  = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH_CNTS - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CNTS - 1);

  // Control nibble: A/B select, don't-care, GA, SHDN inactive
  localparam logic [3:0] CFG = {CHANNEL, 1'b0, GAIN_1X, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] pend_word_q, pend_word_d;
  logic               pend_q, pend_d;
  logic               dv_q;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               ldac_q, ldac_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               edge_c;
  logic [FRAME_W-1:0] new_frame_c;

  assign edge_c      = bus.dv_in & ~dv_q;
  assign new_frame_c = {CFG, bus.data_in};

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    hold_d      = hold_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    ldac_d      = ldac_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = 1'b0;

    if (state_q != ST_IDLE && edge_c) begin
      pend_word_d = new_frame_c;
      pend_d      = 1'b1;
      ovf_d       = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q || edge_c) begin
          state_d = ST_SHIFT;
          frame_d = pend_q ? pend_word_q : new_frame_c;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = frame_d[FRAME_W-1];
          div_d   = '0;
          bit_d   = BIT_W'(FRAME_W - 1);
          busy_d  = 1'b1;
          // A simultaneous edge refills the slot being drained, without overflow
          if (pend_q) begin
            pend_d = edge_c;
            if (edge_c) pend_word_d = new_frame_c;
          end
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = 1'b0;
          if (bit_q == '0) begin
            state_d = ST_CS_HOLD;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            hold_d  = '0;
          end else begin
            bit_d  = bit_q - BIT_W'(1);
            mosi_d = frame_q[bit_d];
          end
        end else begin
          div_d = div_q + CNT_W'(1);
          sck_d = (div_d >= DIV_HALF);
        end
      end
      ST_CS_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_LDAC;
          ldac_d  = 1'b0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      ST_LDAC: begin
        if (hold_q == LDAC_LAST) begin
          state_d = ST_IDLE;
          ldac_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      hold_q      <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      dv_q        <= 1'b1;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ldac_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      dv_q        <= bus.dv_in;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ldac_q      <= ldac_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.cs   = cs_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.ldac = ldac_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_spi_mcp4822_dac.sv
// Bench for spi_mcp4822_dac: three parameter variants share one stimulus stream;
// frames and timing are compared against an edge-schedule model.
module tb_spi_mcp4822_dac;

  localparam int CLK_DIV    = 8;
  localparam int CS_HIGH    = 2;
  localparam int LDAC_LEN   = 2;
  localparam int FRAME_CLKS = 16 * CLK_DIV + CS_HIGH + LDAC_LEN + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] data;
  logic        dv;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_mcp4822_dac_if if0 ();
  spi_mcp4822_dac_if if1 ();
  spi_mcp4822_dac_if if2 ();

  assign if0.data_in = data;  assign if0.dv_in = dv;
  assign if1.data_in = data;  assign if1.dv_in = dv;
  assign if2.data_in = data;  assign if2.dv_in = dv;

  spi_mcp4822_dac #(.CLK_DIV(CLK_DIV), .CHANNEL(1'b0), .GAIN_1X(1'b1),
                    .CS_HIGH_CNTS(CS_HIGH), .LDAC_CNTS(LDAC_LEN))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  spi_mcp4822_dac #(.CLK_DIV(CLK_DIV), .CHANNEL(1'b1), .GAIN_1X(1'b1),
                    .CS_HIGH_CNTS(CS_HIGH), .LDAC_CNTS(LDAC_LEN))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  spi_mcp4822_dac #(.CLK_DIV(CLK_DIV), .CHANNEL(1'b0), .GAIN_1X(1'b0),
                    .CS_HIGH_CNTS(CS_HIGH), .LDAC_CNTS(LDAC_LEN))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

  logic [2:0] cs_w, sck_w, mosi_w;
  assign cs_w   = {if2.cs,   if1.cs,   if0.cs};
  assign sck_w  = {if2.sck,  if1.sck,  if0.sck};
  assign mosi_w = {if2.mosi, if1.mosi, if0.mosi};

  // Bus monitor: mosi captured on sck rising edges while cs is low
  logic [2:0]  cs_p = 3'b111;
  logic [2:0]  sck_p = 3'b000;
  logic        ldac_p = 1'b1;
  logic [15:0] sh [3];
  int          nb [3];
  logic [15:0] last_fr [3];
  bit          want_srise;
  int          q_fall[$], q_rise[$], q_lfall[$], q_done[$], q_ovf[$], q_srise[$], q_nb[$];
  logic [15:0] q_fr[$];
  int          busy_cnt;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!cs_w[i] && cs_p[i]) begin
        sh[i] = '0;
        nb[i] = 0;
        if (i == 0) begin q_fall.push_back(cyc); want_srise = 1'b1; end
      end
      if (!cs_w[i] && sck_w[i] && !sck_p[i]) begin
        sh[i] = {sh[i][14:0], mosi_w[i]};
        nb[i]++;
        if (i == 0 && want_srise) begin q_srise.push_back(cyc); want_srise = 1'b0; end
      end
      if (cs_w[i] && !cs_p[i]) begin
        last_fr[i] = sh[i];
        if (i == 0) begin q_rise.push_back(cyc); q_fr.push_back(sh[i]); q_nb.push_back(nb[i]); end
      end
      cs_p[i]  = cs_w[i];
      sck_p[i] = sck_w[i];
    end
    if (!if0.ldac && ldac_p) q_lfall.push_back(cyc);
    ldac_p = if0.ldac;
    if (if0.done) q_done.push_back(cyc);
    if (if0.ovf)  q_ovf.push_back(cyc);
    if (if0.busy) busy_cnt++;
  end

  task automatic clear_mon();
    q_fall.delete(); q_rise.delete(); q_lfall.delete(); q_done.delete();
    q_ovf.delete(); q_srise.delete(); q_nb.delete(); q_fr.delete();
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) last_fr[i] = '0;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] frame_of(input bit ch, input bit ga, input logic [11:0] d);
    return {ch, 1'b0, ga, 1'b1, d};
  endfunction

  // Reference model: edge schedule -> frames sent, their start cycles, ovf pulse cycles
  int          m_t[$];
  logic [11:0] m_d[$];
  int          exp_start[$], exp_ovf[$];
  logic [15:0] exp_fr[$];

  task automatic run_model();
    int          cur_end;
    bit          pend;
    logic [11:0] pw;
    cur_end = 0; pend = 1'b0; pw = '0;
    exp_start.delete(); exp_ovf.delete(); exp_fr.delete();
    foreach (m_t[k]) begin
      int t;
      t = m_t[k];
      if (pend && t >= cur_end) begin
        exp_start.push_back(cur_end);
        exp_fr.push_back(frame_of(1'b0, 1'b1, pw));
        cur_end = cur_end + FRAME_CLKS;
        pend = 1'b0;
      end
      if (t >= cur_end) begin
        exp_start.push_back(t);
        exp_fr.push_back(frame_of(1'b0, 1'b1, m_d[k]));
        cur_end = t + FRAME_CLKS;
      end else begin
        if (pend) exp_ovf.push_back(t + 1);
        pend = 1'b1;
        pw = m_d[k];
      end
    end
    if (pend) begin
      exp_start.push_back(cur_end);
      exp_fr.push_back(frame_of(1'b0, 1'b1, pw));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic raise(input logic [11:0] d, output int e);
    data = d;
    dv   = 1'b1;
    e    = cyc;
    m_t.push_back(e);
    m_d.push_back(d);
    step(4);
    dv = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    run_model();
    check({tag, "_nframes"}, q_fr.size(), exp_fr.size());
    foreach (exp_fr[k]) begin
      check($sformatf("%s_frame%0d", tag, k), 32'(q_fr[k]), 32'(exp_fr[k]));
      check($sformatf("%s_csfall%0d", tag, k), q_fall[k], exp_start[k] + 1);
    end
    check({tag, "_novf"}, q_ovf.size(), exp_ovf.size());
    foreach (exp_ovf[k]) check($sformatf("%s_ovfcyc%0d", tag, k), q_ovf[k], exp_ovf[k]);
  endtask

  initial begin
    int          e, e2;
    logic [11:0] d;
    logic [11:0] vals [4];
    vals[0] = 12'h123; vals[1] = 12'hFFF; vals[2] = 12'h000; vals[3] = 12'($urandom);

    // Reset with dv_in already high
    rst_n = 1'b0; dv = 1'b1; data = 12'h5A5;
    clear_mon();
    step(4);
    check("rst_cs", 32'(if0.cs), 1);
    check("rst_sck", 32'(if0.sck), 0);
    check("rst_mosi", 32'(if0.mosi), 0);
    check("rst_ldac", 32'(if0.ldac), 1);
    check("rst_busy", 32'(if0.busy), 0);
    check("rst_done_ovf", 32'({if0.done, if0.ovf}), 0);
    clear_mon();
    rst_n = 1'b1;
    step(20);
    check("rst_no_frame", q_fall.size(), 0);
    check("rst_no_busy", busy_cnt, 0);
    dv = 1'b0;
    step(3);

    // Single frame and its timing
    clear_mon(); m_t.delete(); m_d.delete();
    raise(12'hABC, e);
    step(150);
    check("single_frame", 32'(q_fr[0]), 32'h3ABC);
    check("single_nbits", q_nb[0], 16);
    check("single_csfall", q_fall[0], e + 1);
    check("single_sckrise", q_srise[0], e + 1 + CLK_DIV / 2);
    check("single_cslow", q_rise[0] - q_fall[0], 16 * CLK_DIV);
    check("single_ldacfall", q_lfall[0], e + 1 + 16 * CLK_DIV + CS_HIGH);
    check("single_ldaclow", q_done[0] - q_lfall[0], LDAC_LEN);
    check("single_done", q_done[0], e + 133);
    check("single_ndone", q_done.size(), 1);
    check("single_busy", busy_cnt, 132);
    check("single_ch1", 32'(last_fr[1]), 32'hBABC);
    check("single_gain2x", 32'(last_fr[2]), 32'h1ABC);

    // Parameter variants over directed and random words
    foreach (vals[k]) begin
      clear_mon(); m_t.delete(); m_d.delete();
      raise(vals[k], e);
      step(150);
      check($sformatf("var%0d_dut0", k), 32'(last_fr[0]), 32'(frame_of(1'b0, 1'b1, vals[k])));
      check($sformatf("var%0d_ch1", k), 32'(last_fr[1]), 32'(frame_of(1'b1, 1'b1, vals[k])));
      check($sformatf("var%0d_gain2x", k), 32'(last_fr[2]), 32'(frame_of(1'b0, 1'b0, vals[k])));
    end

    // Pending: second edge 50 cycles into the first frame
    clear_mon(); m_t.delete(); m_d.delete();
    raise(12'($urandom), e);
    wait_until(e + 50);
    raise(12'($urandom), e2);
    step(300);
    compare_model("pend");
    check("pend_after_done", q_fall[1], q_done[0] + 1);
    check("pend_gap", q_fall[1] - q_rise[0], CS_HIGH + LDAC_LEN + 1);

    // Overflow: three edges inside one frame
    clear_mon(); m_t.delete(); m_d.delete();
    raise(12'($urandom), e);
    wait_until(e + 30);
    raise(12'($urandom), e2);
    wait_until(e + 60);
    raise(12'($urandom), e2);
    step(300);
    compare_model("ovf");
    check("ovf_cycle", q_ovf[0], e + 61);

    // Reset mid-frame with a sample pending
    clear_mon(); m_t.delete(); m_d.delete();
    raise(12'($urandom), e);
    wait_until(e + 20);
    raise(12'($urandom), e2);
    wait_until(e + 40);
    rst_n = 1'b0;
    #1;
    check("midrst_cs", 32'(if0.cs), 1);
    check("midrst_sck", 32'(if0.sck), 0);
    check("midrst_ldac", 32'(if0.ldac), 1);
    step(3);
    rst_n = 1'b1;
    clear_mon(); m_t.delete(); m_d.delete();
    step(200);
    check("midrst_no_frame", q_fall.size(), 0);
    check("midrst_no_busy", busy_cnt, 0);
    d = 12'($urandom);
    raise(d, e);
    step(150);
    compare_model("midrst_fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
